// File: rtl/dvp_axis_pkg.sv
// rtl/dvp_axis_pkg.sv - shared types and constants for the DVP to AXI-Stream packer
package dvp_axis_pkg;

   localparam int FRAME_CNT_W = 16;

   typedef enum logic [1:0] {
      WAIT_VSYNC = 2'd0,
      WAIT_SOF   = 2'd1,
      ACTIVE     = 2'd2,
      DROP       = 2'd3
   } state_e;

endpackage

// File: rtl/dvp_axis_fifo.sv
// rtl/dvp_axis_fifo.sv - synchronous show-ahead FIFO, push accepted when full if a pop coincides
module dvp_axis_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; the top masks the head while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/dvp_axis_pack.sv
// rtl/dvp_axis_pack.sv - DVP camera receiver packing bus beats into AXI-Stream pixels
module dvp_axis_pack
   import dvp_axis_pkg::*;
#(
   parameter int                     DATA_W         = 8,
   parameter int                     BYTES_PER_PIX  = 2,
   parameter int                     FIFO_DEPTH     = 16,
   parameter int                     TDATA_W        = DATA_W * BYTES_PER_PIX,
   parameter logic [FRAME_CNT_W-1:0] FRAME_CNT_INIT = '0
) (
   input  logic                   pclk_i,
   input  logic                   rst_i,
   input  logic                   vsync_i,
   input  logic                   hsync_i,
   input  logic [DATA_W-1:0]      data_i,
   output logic [TDATA_W-1:0]     tdata_o,
   output logic [TDATA_W/8-1:0]   tkeep_o,
   output logic [TDATA_W/8-1:0]   tstrb_o,
   output logic                   tuser_o,
   output logic                   tlast_o,
   output logic                   tvalid_o,
   input  logic                   tready_i,
   output logic                   overflow_o,
   output logic                   frag_o,
   input  logic                   err_clr_i,
   output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   if ((TDATA_W % 8) != 0) begin : g_bad_tdata_w
      $error("dvp_axis_pack: TDATA_W must be a multiple of 8");
   end
   if (BYTES_PER_PIX < 1 || BYTES_PER_PIX > 4) begin : g_bad_bpp
      $error("dvp_axis_pack: BYTES_PER_PIX must be 1..4");
   end
   if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("dvp_axis_pack: FIFO_DEPTH must be a power of two >= 4");
   end

   logic               vsync_q, hsync_q, hsync_q_d;
   logic [DATA_W-1:0]  data_q;
   state_e             state, state_nxt;
   logic [1:0]         beat_cnt, beat_cnt_nxt;
   logic [TDATA_W-1:0] pix_sr, pix_sr_nxt, pix_new;
   logic [TDATA_W-1:0] hold_data, hold_data_nxt;
   logic               hold_valid, hold_valid_nxt;
   logic               sof_pending, sof_pending_nxt;
   logic               push_req, push_last, push_ok, pop;
   logic               frag_set, ovf_set;
   logic               line_end, pix_done;
   logic               fifo_full, fifo_empty;
   logic [CW-1:0]      fifo_count;
   logic [TDATA_W+1:0] head;

   // Older beats shift toward the MSBs, so the first beat of a pixel ends on top.
   assign pix_new  = (pix_sr << DATA_W) | TDATA_W'(data_q);
   assign line_end = !hsync_q && hsync_q_d;
   assign pix_done = hsync_q && (beat_cnt == 2'(BYTES_PER_PIX - 1));
   assign pop      = tvalid_o && tready_i;
   assign push_ok  = !fifo_full || pop;

   always_ff @(posedge pclk_i) begin
      if (rst_i) begin
         vsync_q     <= 1'b0;
         hsync_q     <= 1'b0;
         hsync_q_d   <= 1'b0;
         data_q      <= '0;
         state       <= WAIT_VSYNC;
         beat_cnt    <= '0;
         pix_sr      <= '0;
         hold_data   <= '0;
         hold_valid  <= 1'b0;
         sof_pending <= 1'b0;
         frame_cnt_o <= FRAME_CNT_INIT;
         overflow_o  <= 1'b0;
         frag_o      <= 1'b0;
      end else begin
         vsync_q     <= vsync_i;
         hsync_q     <= hsync_i;
         hsync_q_d   <= hsync_q;
         data_q      <= data_i;
         state       <= state_nxt;
         beat_cnt    <= beat_cnt_nxt;
         pix_sr      <= pix_sr_nxt;
         hold_data   <= hold_data_nxt;
         hold_valid  <= hold_valid_nxt;
         sof_pending <= sof_pending_nxt;
         if (push_req && push_ok && sof_pending) frame_cnt_o <= frame_cnt_o + 1'b1;
         if (ovf_set)        overflow_o <= 1'b1;
         else if (err_clr_i) overflow_o <= 1'b0;
         if (frag_set)       frag_o <= 1'b1;
         else if (err_clr_i) frag_o <= 1'b0;
      end
   end

   always_comb begin
      state_nxt       = state;
      beat_cnt_nxt    = beat_cnt;
      pix_sr_nxt      = pix_sr;
      hold_data_nxt   = hold_data;
      hold_valid_nxt  = hold_valid;
      sof_pending_nxt = sof_pending;
      push_req        = 1'b0;
      push_last       = 1'b0;
      frag_set        = 1'b0;
      ovf_set         = 1'b0;
      case (state)
         WAIT_VSYNC: begin
            if (vsync_q) state_nxt = WAIT_SOF;
         end
         WAIT_SOF: begin
            beat_cnt_nxt   = '0;
            hold_valid_nxt = 1'b0;
            if (!vsync_q) begin
               state_nxt       = ACTIVE;
               sof_pending_nxt = 1'b1;
            end
         end
         ACTIVE: begin
            if (vsync_q) begin
               state_nxt      = WAIT_SOF;
               push_req       = hold_valid;
               push_last      = 1'b1;
               hold_valid_nxt = 1'b0;
               beat_cnt_nxt   = '0;
            end else if (hsync_q) begin
               pix_sr_nxt = pix_new;
               if (pix_done) begin
                  beat_cnt_nxt   = '0;
                  push_req       = hold_valid;
                  hold_data_nxt  = pix_new;
                  hold_valid_nxt = 1'b1;
               end else begin
                  beat_cnt_nxt = beat_cnt + 1'b1;
               end
            end else if (line_end) begin
               push_req       = hold_valid;
               push_last      = 1'b1;
               hold_valid_nxt = 1'b0;
               if (beat_cnt != '0) begin
                  frag_set     = 1'b1;
                  beat_cnt_nxt = '0;
               end
            end
            // A refused push loses the rest of the frame; a vsync flush already starts the next one.
            if (push_req && !push_ok) begin
               ovf_set        = 1'b1;
               state_nxt      = vsync_q ? WAIT_SOF : DROP;
               hold_valid_nxt = 1'b0;
               beat_cnt_nxt   = '0;
            end
         end
         DROP: begin
            hold_valid_nxt = 1'b0;
            beat_cnt_nxt   = '0;
            if (vsync_q) state_nxt = WAIT_SOF;
         end
         default: state_nxt = WAIT_VSYNC;
      endcase
      if (push_req && push_ok) sof_pending_nxt = 1'b0;
   end

   dvp_axis_fifo #(
      .WIDTH (TDATA_W + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (pclk_i),
      .rst   (rst_i),
      .push  (push_req && push_ok),
      .wdata ({sof_pending, push_last, hold_data}),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign tvalid_o                     = (fifo_count != '0);
   assign {tuser_o, tlast_o, tdata_o}  = fifo_empty ? '0 : head;
   assign tkeep_o                      = '1;
   assign tstrb_o                      = '1;

endmodule

// File: tb/tb_dvp_axis_pack.sv
// tb/tb_dvp_axis_pack.sv - directed self-checking bench for dvp_axis_pack
module tb_dvp_axis_pack;

   logic        pclk = 1'b0;
   logic        rst = 1'b1, rst1 = 1'b1;
   logic        vsync = 1'b0, hsync = 1'b0;
   logic [7:0]  data = 8'h00;
   logic        tready = 1'b0, tready1 = 1'b1, err_clr = 1'b0;

   logic [15:0] tdata;
   logic [1:0]  tkeep, tstrb;
   logic        tuser, tlast, tvalid, overflow, frag;
   logic [15:0] frame_cnt;

   logic [7:0]  tdata1;
   logic [0:0]  tkeep1, tstrb1;
   logic        tuser1, tlast1, tvalid1, overflow1, frag1;
   logic [15:0] frame_cnt1;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          rdy_mode = 0;
   logic        rdy_phase = 1'b0, rdy_pick = 1'b0;

   logic [7:0]  line_buf [0:255];
   logic [15:0] got_data [0:511];
   logic        got_user [0:511];
   logic        got_last [0:511];
   int          got_n = 0;
   int          base  = 0;

   always #5 pclk = ~pclk;

   dvp_axis_pack #(.DATA_W(8), .BYTES_PER_PIX(2), .FIFO_DEPTH(16)) u_dut (
      .pclk_i(pclk), .rst_i(rst), .vsync_i(vsync), .hsync_i(hsync), .data_i(data),
      .tdata_o(tdata), .tkeep_o(tkeep), .tstrb_o(tstrb), .tuser_o(tuser), .tlast_o(tlast),
      .tvalid_o(tvalid), .tready_i(tready), .overflow_o(overflow), .frag_o(frag),
      .err_clr_i(err_clr), .frame_cnt_o(frame_cnt)
   );

   dvp_axis_pack #(.DATA_W(8), .BYTES_PER_PIX(1), .FIFO_DEPTH(4), .FRAME_CNT_INIT(16'hFFFF)) u_dut1 (
      .pclk_i(pclk), .rst_i(rst1), .vsync_i(vsync), .hsync_i(hsync), .data_i(data),
      .tdata_o(tdata1), .tkeep_o(tkeep1), .tstrb_o(tstrb1), .tuser_o(tuser1), .tlast_o(tlast1),
      .tvalid_o(tvalid1), .tready_i(tready1), .overflow_o(overflow1), .frag_o(frag1),
      .err_clr_i(1'b0), .frame_cnt_o(frame_cnt1)
   );

   // Mode 2 gives exactly one ready cycle, at a random slot, in every pair of cycles.
   always @(posedge pclk) begin
      #2;
      case (rdy_mode)
         0: tready = 1'b0;
         1: tready = 1'b1;
         default: begin
            if (!rdy_phase) rdy_pick = 1'($urandom_range(0, 1));
            tready    = (rdy_phase == rdy_pick);
            rdy_phase = ~rdy_phase;
         end
      endcase
   end

   always @(negedge pclk) begin
      if (tvalid && tready) begin
         if (got_n < 512) begin
            got_data[got_n] = tdata;
            got_user[got_n] = tuser;
            got_last[got_n] = tlast;
         end
         got_n++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic v, input logic h, input logic [7:0] d);
      vsync = v;
      hsync = h;
      data  = d;
      @(posedge pclk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
   endtask

   task automatic vpulse();
      cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 8'h00);
      idle(2);
   endtask

   task automatic send_line(input int nbytes);
      for (int i = 0; i < nbytes; i++) cyc(1'b0, 1'b1, line_buf[i]);
      cyc(1'b0, 1'b0, 8'h00);
   endtask

   task automatic wait_beats(input int n, input int budget);
      int k;
      k = 0;
      while ((got_n - base) < n && k < budget) begin
         idle(1);
         k++;
      end
   endtask

   task automatic expect_beat(input string pfx, input int idx, input int d, input int u, input int l);
      check_eq($sformatf("%s_data%0d", pfx, idx), 32'(got_data[base + idx]), d);
      check_eq($sformatf("%s_user%0d", pfx, idx), 32'(got_user[base + idx]), u);
      check_eq($sformatf("%s_last%0d", pfx, idx), 32'(got_last[base + idx]), l);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] pat;
      int          nl;

      repeat (3) @(posedge pclk);
      #1;
      check_eq("rst_tvalid", 32'(tvalid), 0);
      check_eq("rst_tdata", 32'(tdata), 0);
      check_eq("rst_tuser", 32'(tuser), 0);
      check_eq("rst_tlast", 32'(tlast), 0);
      check_eq("rst_overflow", 32'(overflow), 0);
      check_eq("rst_frag", 32'(frag), 0);
      check_eq("rst_frame_cnt", 32'(frame_cnt), 0);
      check_eq("rst_tkeep", 32'(tkeep), 'h3);
      check_eq("rst_tstrb", 32'(tstrb), 'h3);
      rst = 1'b0;
      idle(2);

      // Basic packing
      rdy_mode = 1;
      base = got_n;
      vpulse();
      pat = 64'h1234_5678_9ABC_DEF0;
      for (int i = 0; i < 8; i++) line_buf[i] = pat[63 - 8*i -: 8];
      send_line(8);
      wait_beats(4, 20);
      idle(2);
      check_eq("basic_count", 32'(got_n - base), 4);
      expect_beat("basic", 0, 'h1234, 1, 0);
      expect_beat("basic", 1, 'h5678, 0, 0);
      expect_beat("basic", 2, 'h9ABC, 0, 0);
      expect_beat("basic", 3, 'hDEF0, 0, 1);
      check_eq("basic_frame_cnt", 32'(frame_cnt), 1);
      check_eq("basic_tvalid_idle", 32'(tvalid), 0);

      // Fragment
      base = got_n;
      for (int i = 0; i < 5; i++) line_buf[i] = 8'(i + 1);
      send_line(5);
      wait_beats(2, 20);
      idle(3);
      check_eq("frag_count", 32'(got_n - base), 2);
      expect_beat("frag", 0, 'h0102, 0, 0);
      expect_beat("frag", 1, 'h0304, 0, 1);
      check_eq("frag_set", 32'(frag), 1);
      check_eq("frag_no_overflow", 32'(overflow), 0);
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      check_eq("frag_cleared", 32'(frag), 0);

      // Overflow and recovery
      rdy_mode = 0;
      base = got_n;
      vpulse();
      for (int i = 0; i < 40; i++) begin
         line_buf[2*i]     = 8'hA0;
         line_buf[2*i + 1] = 8'(i);
      end
      send_line(80);
      idle(3);
      check_eq("ovf_set", 32'(overflow), 1);
      check_eq("ovf_tvalid", 32'(tvalid), 1);
      check_eq("ovf_no_pop", 32'(got_n - base), 0);
      rdy_mode = 1;
      wait_beats(16, 40);
      idle(10);
      check_eq("ovf_drain_count", 32'(got_n - base), 16);
      nl = 0;
      for (int i = 0; i < 16; i++) nl += int'(got_last[base + i]);
      check_eq("ovf_tlast_count", 32'(nl), 0);
      expect_beat("ovf", 0, 'hA000, 1, 0);
      expect_beat("ovf", 15, 'hA00F, 0, 0);

      base = got_n;
      vpulse();
      pat = 64'h1122_3344_5566_7788;
      for (int i = 0; i < 8; i++) line_buf[i] = pat[63 - 8*i -: 8];
      send_line(8);
      wait_beats(4, 20);
      idle(2);
      check_eq("rec_count", 32'(got_n - base), 4);
      expect_beat("rec", 0, 'h1122, 1, 0);
      expect_beat("rec", 1, 'h3344, 0, 0);
      expect_beat("rec", 2, 'h5566, 0, 0);
      expect_beat("rec", 3, 'h7788, 0, 1);
      check_eq("rec_frame_cnt", 32'(frame_cnt), 3);
      check_eq("rec_overflow_sticky", 32'(overflow), 1);
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      check_eq("ovf_cleared", 32'(overflow), 0);

      // Mid-frame start: reset released inside a line, then a line with no vsync
      base = got_n;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'(8'h40 + i));
      rst = 1'b0;
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(8'h50 + i));
      idle(3);
      for (int i = 0; i < 4; i++) line_buf[i] = 8'(8'h60 + i);
      send_line(4);
      idle(4);
      check_eq("mid_no_output", 32'(got_n - base), 0);
      check_eq("mid_tvalid", 32'(tvalid), 0);
      check_eq("mid_frame_cnt", 32'(frame_cnt), 0);
      vpulse();
      pat = 64'hCAFE_BEEF_0000_0000;
      for (int i = 0; i < 4; i++) line_buf[i] = pat[63 - 8*i -: 8];
      send_line(4);
      wait_beats(2, 20);
      idle(2);
      check_eq("mid_count", 32'(got_n - base), 2);
      expect_beat("mid", 0, 'hCAFE, 1, 0);
      expect_beat("mid", 1, 'hBEEF, 0, 1);
      check_eq("mid_frame_cnt_after", 32'(frame_cnt), 1);

      // Random backpressure, three back-to-back 64-pixel lines
      rdy_mode = 2;
      base = got_n;
      vpulse();
      for (int l = 0; l < 3; l++) begin
         for (int n = 0; n < 64; n++) begin
            line_buf[2*n]     = 8'(l);
            line_buf[2*n + 1] = 8'(n);
         end
         send_line(128);
      end
      wait_beats(192, 600);
      idle(4);
      check_eq("bp_count", 32'(got_n - base), 192);
      for (int l = 0; l < 3; l++) begin
         for (int n = 0; n < 64; n++) begin
            expect_beat("bp", l*64 + n, l*256 + n, (l == 0 && n == 0) ? 1 : 0, (n == 63) ? 1 : 0);
         end
      end
      check_eq("bp_overflow", 32'(overflow), 0);
      check_eq("bp_frame_cnt", 32'(frame_cnt), 2);

      // Push into a full FIFO in the same cycle as a pop
      rdy_mode = 0;
      idle(2);
      base = got_n;
      vpulse();
      for (int i = 0; i < 17; i++) begin
         line_buf[2*i]     = 8'hB0;
         line_buf[2*i + 1] = 8'(i);
      end
      send_line(34);
      rdy_mode = 1;
      idle(1);
      rdy_mode = 0;
      check_eq("full_pp_overflow", 32'(overflow), 0);
      check_eq("full_pp_one_pop", 32'(got_n - base), 1);
      rdy_mode = 1;
      wait_beats(17, 40);
      idle(3);
      check_eq("full_pp_count", 32'(got_n - base), 17);
      expect_beat("full_pp", 0, 'hB000, 1, 0);
      expect_beat("full_pp", 16, 'hB010, 0, 1);
      check_eq("full_pp_overflow_end", 32'(overflow), 0);

      // One beat per pixel: line-end latency and frame counter wrap
      rst1 = 1'b0;
      idle(1);
      check_eq("bpp1_frame_cnt_init", 32'(frame_cnt1), 'hFFFF);
      vpulse();
      cyc(1'b0, 1'b1, 8'h5A);
      cyc(1'b0, 1'b0, 8'h00);
      check_eq("bpp1_tvalid_k", 32'(tvalid1), 0);
      idle(1);
      check_eq("bpp1_tvalid_k1", 32'(tvalid1), 1);
      check_eq("bpp1_tlast_k1", 32'(tlast1), 1);
      check_eq("bpp1_tuser_k1", 32'(tuser1), 1);
      check_eq("bpp1_tdata_k1", 32'(tdata1), 'h5A);
      check_eq("bpp1_frame_cnt_wrap", 32'(frame_cnt1), 0);
      idle(1);
      check_eq("bpp1_tvalid_drained", 32'(tvalid1), 0);
      check_eq("bpp1_overflow", 32'(overflow1), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
